// File: rtl/serial_pkg.sv
// Shared definitions for the position-frame serial link (transmitter and
// receptor_serial): receiver state encoding, frame geometry and line levels.
package serial_pkg;

  typedef enum logic [2:0] {
    RESYNC = 3'd0,
    IDLE   = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    STOP   = 3'd4,
    GAP    = 3'd5
  } state_t;

  localparam int   FRAME_BYTES = 3;
  localparam int   BYTE_BITS   = 8;
  localparam logic START_BIT   = 1'b0;
  localparam logic STOP_BIT    = 1'b1;

endpackage

// File: rtl/serial_byte_rx.sv
// Single-byte receiver: start-bit qualification, 8 centre-sampled data bits
// (LSB first) and stop-bit check. Kicked by a one-cycle start pulse on the
// falling edge seen by the parent; reports one registered result per byte.
module serial_byte_rx
  import serial_pkg::*;
#(
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 line,
  input  logic                 start,
  output logic                 byte_done,
  output logic                 byte_ok,
  output logic                 false_start,
  output logic [BYTE_BITS-1:0] data
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int IW = $clog2(BYTE_BITS);
  localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] LAST_BIT = IW'(BYTE_BITS - 1);

  state_t               st;
  logic [CW-1:0]        bit_cnt;
  logic [IW-1:0]        bit_idx;
  logic [BYTE_BITS-1:0] shift_reg;

  // Byte sequencer; bit_cnt runs a full bit period from the start-bit centre
  // so every later sample lands in the middle of its bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      st          <= IDLE;
      bit_cnt     <= '0;
      bit_idx     <= '0;
      shift_reg   <= '0;
      byte_done   <= 1'b0;
      byte_ok     <= 1'b0;
      false_start <= 1'b0;
    end else begin
      byte_done   <= 1'b0;
      false_start <= 1'b0;
      case (st)
        IDLE: begin
          if (start) begin
            st      <= START;
            bit_cnt <= '0;
          end
        end
        START: begin
          if (bit_cnt == HALF) begin
            bit_cnt <= '0;
            if (line != START_BIT) begin
              // low pulse shorter than half a bit: a glitch, not a byte
              false_start <= 1'b1;
              st          <= IDLE;
            end else begin
              bit_idx <= '0;
              st      <= DATA;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        DATA: begin
          bit_cnt <= (bit_cnt == LAST) ? '0 : bit_cnt + 1'b1;
          if (bit_cnt == LAST) begin
            shift_reg <= {line, shift_reg[BYTE_BITS-1:1]};
            bit_idx   <= bit_idx + 1'b1;
            if (bit_idx == LAST_BIT) st <= STOP;
          end
        end
        STOP: begin
          bit_cnt <= (bit_cnt == LAST) ? '0 : bit_cnt + 1'b1;
          if (bit_cnt == LAST) begin
            byte_done <= 1'b1;
            byte_ok   <= (line == STOP_BIT);
            st        <= IDLE;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign data = shift_reg;

endmodule

// File: rtl/receptor_serial.sv
// Serial receptor for the 3-byte (x, y, z) arm position frame. Owns line
// synchronisation, idle detection, inter-byte gap timeout and frame assembly;
// publishes a complete frame atomically with a one-cycle valid strobe.
// Optional build macro RECEPTOR_SERIAL_STATS_EN adds frame_count/error_count.
module receptor_serial
  import serial_pkg::*;
#(
  parameter int OVERSAMPLE       = 16,
  parameter int GAP_TIMEOUT_BITS = 2,
  parameter int RESYNC_BITS      = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       canal_serial,
  output logic [7:0] x,
  output logic [7:0] y,
  output logic [7:0] z,
  output logic       valid,
  output logic       frame_error
`ifdef RECEPTOR_SERIAL_STATS_EN
  ,
  output logic [15:0] frame_count,
  output logic [15:0] error_count
`endif
);

  localparam int TW = $clog2(RESYNC_BITS * OVERSAMPLE + 1);
  localparam logic [TW-1:0] RESYNC_LAST = TW'(RESYNC_BITS * OVERSAMPLE - 1);
  localparam logic [TW-1:0] GAP_LAST    = TW'(GAP_TIMEOUT_BITS * OVERSAMPLE - 1);
  localparam logic [1:0]    LAST_BYTE   = 2'(FRAME_BYTES - 1);

  logic [1:0]           sync;
  logic                 line;
  state_t               state;
  logic [TW-1:0]        tmo_cnt;
  logic [1:0]           byte_idx;
  logic [BYTE_BITS-1:0] shadow0;
  logic [BYTE_BITS-1:0] shadow1;
  logic                 start;
  logic                 byte_done;
  logic                 byte_ok;
  logic                 false_start;
  logic [BYTE_BITS-1:0] rx_data;

  // Two-flop synchroniser; resets to the idle (high) level.
  always_ff @(posedge clk) begin
    if (rst) sync <= 2'b11;
    else     sync <= {sync[0], canal_serial};
  end

  assign line  = sync[1];
  assign start = ((state == IDLE) || (state == GAP)) && (line == START_BIT);

  serial_byte_rx #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_byte_rx (
    .clk        (clk),
    .rst        (rst),
    .line       (line),
    .start      (start),
    .byte_done  (byte_done),
    .byte_ok    (byte_ok),
    .false_start(false_start),
    .data       (rx_data)
  );

  // Frame-level FSM; START here means the byte receiver is engaged and the
  // top level waits for its verdict.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RESYNC;
      tmo_cnt     <= '0;
      byte_idx    <= '0;
      shadow0     <= '0;
      shadow1     <= '0;
      x           <= '0;
      y           <= '0;
      z           <= '0;
      valid       <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      valid       <= 1'b0;
      frame_error <= 1'b0;
      case (state)
        RESYNC: begin
          // only a high run longer than any in-frame run marks a frame boundary
          if (line != STOP_BIT) begin
            tmo_cnt <= '0;
          end else if (tmo_cnt == RESYNC_LAST) begin
            tmo_cnt <= '0;
            state   <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        IDLE: begin
          if (start) state <= START;
        end
        START: begin
          if (false_start) begin
            // a glitch between bytes also drops the partial frame, quietly
            byte_idx <= '0;
            state    <= IDLE;
          end else if (byte_done) begin
            if (!byte_ok) begin
              frame_error <= 1'b1;
              byte_idx    <= '0;
              tmo_cnt     <= '0;
              state       <= RESYNC;
            end else if (byte_idx == LAST_BYTE) begin
              x        <= shadow0;
              y        <= shadow1;
              z        <= rx_data;
              valid    <= 1'b1;
              byte_idx <= '0;
              state    <= IDLE;
            end else begin
              if (byte_idx == 2'd0) shadow0 <= rx_data;
              else                  shadow1 <= rx_data;
              byte_idx <= byte_idx + 1'b1;
              tmo_cnt  <= '0;
              state    <= GAP;
            end
          end
        end
        GAP: begin
          if (start) begin
            state <= START;
          end else if (tmo_cnt == GAP_LAST) begin
            frame_error <= 1'b1;
            byte_idx    <= '0;
            tmo_cnt     <= '0;
            state       <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: state <= RESYNC;
      endcase
    end
  end

`ifdef RECEPTOR_SERIAL_STATS_EN
  // Free-running event counters, wrapping naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_count <= '0;
      error_count <= '0;
    end else begin
      if (valid)       frame_count <= frame_count + 16'd1;
      if (frame_error) error_count <= error_count + 16'd1;
    end
  end
`endif

endmodule

// File: doc/receptor_serial.md
Name: receptor_serial

Overview:
- Receives the 3-byte position frame from the serial transmitter and recovers the x, y and z bytes.
- Line format: idle high. Each byte is a start bit (0), 8 data bits LSB first, then a stop bit (1). The three bytes are sent back-to-back in the order x, y, z, with no gap. Frames are separated by a long idle-high period.
- The block runs on a clock that is OVERSAMPLE times the bit rate. It publishes each complete frame atomically with a one-cycle valid strobe, for use by the arm position controller.

Parameters:
- OVERSAMPLE, 16, clk cycles per serial bit (even, ≥4).
- GAP_TIMEOUT_BITS, 2, bit times the line may stay high between bytes of one frame before the partial frame is aborted.
- RESYNC_BITS, 12, bit times of continuous high needed to declare the line idle. Must exceed 9, the longest high run inside a frame.

Ports:
- clk  input  1  system clock, OVERSAMPLE × bit rate.
- rst  input  1  synchronous reset, active-high.
- canal_serial  input  1  asynchronous serial line.
- x  output  8  last good x byte.
- y  output  8  last good y byte.
- z  output  8  last good z byte.
- valid  output  1  one-cycle pulse when x, y and z are updated.
- frame_error  output  1  one-cycle pulse when a frame is discarded.

Behaviour:
- Synchronizer: 2-flop synchronizer on canal_serial, both flops reset to 1. All decisions use the synchronized line.
- Reset values: x=y=z=0, valid=0, frame_error=0, byte_idx=0, state=RESYNC. Reset mid-frame drops the frame silently, with no error pulse.
- Counters: bit_cnt width is $clog2(OVERSAMPLE). The timeout counter is wide enough for RESYNC_BITS×OVERSAMPLE.
- RESYNC: count consecutive high cycles; any low clears the count. At RESYNC_BITS×OVERSAMPLE, go to IDLE.
- IDLE: on the line low, go to START with bit_cnt=0.
- START: at bit_cnt=OVERSAMPLE/2−1, sample the line.
  - If 1: false start. Go to IDLE, no error.
  - If 0: go to DATA with bit_cnt=0 and bit_idx=0.
- DATA: every OVERSAMPLE cycles (the centre of each bit), shift the sample into shift_reg[7] and shift right. After the 8th sample, go to STOP.
- STOP: after OVERSAMPLE cycles, sample the line.
  - If 0: frame_error pulse, byte_idx=0, go to RESYNC. x, y and z are unchanged.
  - If 1: store shift_reg into shadow[byte_idx].
  - If byte_idx=2: on the next cycle load x←shadow0, y←shadow1, z←shift_reg together, pulse valid, set byte_idx=0, go to IDLE.
  - Otherwise: byte_idx++, go to GAP.
- GAP: on the line low, go to START. If the line stays high GAP_TIMEOUT_BITS×OVERSAMPLE cycles: frame_error pulse, byte_idx=0, go to IDLE.
- Latency: valid is asserted 1 cycle after the stop-bit sample of byte 2, about 29.5 bit times plus 3 cycles after the first start edge.
- Exclusivity: valid and frame_error are never high in the same cycle. Outputs hold between frames.

Optional Feature:
- Macro: RECEPTOR_SERIAL_STATS_EN.
- With the macro defined, add two outputs:
  - frame_count [15:0]: increments on each valid pulse.
  - error_count [15:0]: increments on each frame_error pulse.
  - Both wrap at 0xFFFF→0 and reset to 0.
- Without the macro, these ports and their counters do not exist. Core behaviour is identical.

Decomposition:
- Shared package serial_pkg holds:
  - the state enum (RESYNC, IDLE, START, DATA, STOP, GAP);
  - FRAME_BYTES=3;
  - BYTE_BITS=8;
  - the start-bit value 0 and stop-bit value 1, shared with the transmitter.
- One sub-module, serial_byte_rx, covers START/DATA/STOP for a single byte and outputs byte_done, byte_ok and data[7:0]. The top level owns RESYNC/IDLE/GAP, byte_idx, the shadow registers and the outputs.

Test Plan:
- Reset, then the line high for 12 bits, then a frame with x=0x5A, y=0xC3, z=0x81 → a single valid pulse; x/y/z=5A/C3/81; frame_error stays 0.
- Two frames (01/02/03, then FF/00/FF) separated by 3000 bits idle → two valid pulses; final outputs FF/00/FF.
- Stop bit of byte 1 forced to 0 → frame_error pulse, no valid, outputs keep the previous frame. The next clean frame is received after 12 bits high.
- Line high 2 bits after byte 0 (truncated frame) → frame_error pulse at 32 cycles of high; no valid.
- A 4-cycle low glitch while IDLE → false start, no valid, no error. rst asserted mid-byte 2 → outputs return to 0 and the line is resynced.
- With RECEPTOR_SERIAL_STATS_EN: 3 good frames and 1 bad frame → frame_count=3, error_count=1.
